// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types for the ALU instruction sequencer: operand-source select and opcode layout.
package alu_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      SRC_IMM = 2'd0,
      SRC_REG = 2'd1,
      SRC_MEM = 2'd2
   } data_src_t;

   localparam logic [1:0] SRC_SPECIAL = 2'd3;
   localparam logic [2:0] OP_NOP      = 3'b000;
   localparam logic [2:0] OP_HALT     = 3'b111;

   // Bit layout of an opcode byte, msb first.
   typedef struct packed {
      logic [2:0] op;
      logic [1:0] src;
      logic       wr_cy;
      logic       wr_a;
      logic       cond_z;
   } opcode_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction-stream and memory-read handshake bundle between program memory and the sequencer.
interface alu_seq_ctrl_if;

   logic       instr_valid;
   logic [7:0] instr_data;
   logic       instr_ready;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ack;

   modport master (
      input  instr_valid, instr_data, mem_ack,
      output instr_ready, mem_req, mem_addr
   );

   modport slave (
      output instr_valid, instr_data, mem_ack,
      input  instr_ready, mem_req, mem_addr
   );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Byte-stream instruction sequencer driving operand select, ALU op and write strobes.
// Optional ALU_SEQ_STALL_CNT_EN adds a saturating stall_cnt output.
module alu_seq_ctrl
   import alu_seq_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   alu_seq_ctrl_if.master   bus,
   input  logic             flag_z,
   output data_src_t        data_src,
   output logic [7:0]       immediate,
   output logic [2:0]       reg_sel,
   output logic [2:0]       op,
   output logic             ce_a,
   output logic             ce_cy,
   output logic             busy,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] retired_cnt
`ifdef ALU_SEQ_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   localparam int unsigned TMO_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_OP,
      S_FETCH_ARG,
      S_MEM_WAIT,
      S_EXEC,
      S_RETIRE,
      S_HALT
   } state_t;

   state_t           state, state_nxt;
   opcode_t          opc_q, opc_nxt;
   logic [7:0]       arg_q, arg_nxt;
   logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
   logic             accept_c;
   logic             pass_c;

   data_src_t        data_src_nxt;
   logic [7:0]       immediate_nxt;
   logic [2:0]       reg_sel_nxt;
   logic [2:0]       op_nxt;
   logic [7:0]       mem_addr_nxt;
   logic             instr_ready_nxt;
   logic             mem_req_nxt;
   logic             busy_nxt;
   logic             halted_nxt;
   logic             err_nxt;
   logic [CNT_W-1:0] retired_nxt;

   assign accept_c = bus.instr_valid && bus.instr_ready;

   // Strobes must see flag_z of the EXEC cycle itself, so they decode the live state.
   assign pass_c = !opc_q.cond_z || flag_z;
   assign ce_a   = (state == S_EXEC) && opc_q.wr_a  && pass_c;
   assign ce_cy  = (state == S_EXEC) && opc_q.wr_cy && pass_c;

   // Next-state and next-output decode.
   always_comb begin
      state_nxt     = state;
      opc_nxt       = opc_q;
      arg_nxt       = arg_q;
      tmo_nxt       = '0;
      data_src_nxt  = data_src;
      immediate_nxt = immediate;
      reg_sel_nxt   = reg_sel;
      op_nxt        = op;
      mem_addr_nxt  = bus.mem_addr;
      err_nxt       = 1'b0;
      retired_nxt   = retired_cnt;

      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = S_FETCH_OP;
         end
         S_FETCH_OP: begin
            if (accept_c) begin
               opc_nxt = opcode_t'(bus.instr_data);
               if (opc_nxt.src == SRC_SPECIAL) begin
                  if (opc_nxt.op == OP_HALT) begin
                     state_nxt = S_HALT;
                  end else begin
                     state_nxt = S_RETIRE;
                     err_nxt   = (opc_nxt.op != OP_NOP);
                  end
               end else begin
                  state_nxt = S_FETCH_ARG;
               end
            end
         end
         S_FETCH_ARG: begin
            if (accept_c) begin
               arg_nxt = bus.instr_data;
               if (opc_q.src == SRC_MEM) begin
                  state_nxt    = S_MEM_WAIT;
                  mem_addr_nxt = bus.instr_data;
               end else begin
                  state_nxt = S_EXEC;
               end
            end
         end
         S_MEM_WAIT: begin
            if (bus.mem_ack) begin
               state_nxt = S_EXEC;
            end else if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
               // Timed-out instruction is dropped without retiring.
               state_nxt = S_FETCH_OP;
               err_nxt   = 1'b1;
            end else begin
               tmo_nxt = tmo_cnt + TMO_W'(1);
            end
         end
         S_EXEC: begin
            state_nxt = S_RETIRE;
         end
         S_RETIRE: begin
            state_nxt   = S_FETCH_OP;
            retired_nxt = retired_cnt + CNT_W'(1);
         end
         S_HALT: begin
            if (start) state_nxt = S_FETCH_OP;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Datapath controls change only on entry to EXEC and hold until the next one.
      if (state_nxt == S_EXEC) begin
         data_src_nxt  = data_src_t'(opc_nxt.src);
         op_nxt        = opc_nxt.op;
         immediate_nxt = arg_nxt;
         reg_sel_nxt   = arg_nxt[2:0];
      end

      instr_ready_nxt = (state_nxt == S_FETCH_OP) || (state_nxt == S_FETCH_ARG);
      mem_req_nxt     = (state_nxt == S_MEM_WAIT);
      busy_nxt        = (state_nxt != S_IDLE) && (state_nxt != S_HALT);
      halted_nxt      = (state_nxt == S_HALT);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         opc_q           <= '0;
         arg_q           <= '0;
         tmo_cnt         <= '0;
         data_src        <= SRC_IMM;
         immediate       <= '0;
         reg_sel         <= '0;
         op              <= '0;
         bus.mem_addr    <= '0;
         bus.instr_ready <= 1'b0;
         bus.mem_req     <= 1'b0;
         busy            <= 1'b0;
         halted          <= 1'b0;
         err             <= 1'b0;
         retired_cnt     <= '0;
      end else begin
         state           <= state_nxt;
         opc_q           <= opc_nxt;
         arg_q           <= arg_nxt;
         tmo_cnt         <= tmo_nxt;
         data_src        <= data_src_nxt;
         immediate       <= immediate_nxt;
         reg_sel         <= reg_sel_nxt;
         op              <= op_nxt;
         bus.mem_addr    <= mem_addr_nxt;
         bus.instr_ready <= instr_ready_nxt;
         bus.mem_req     <= mem_req_nxt;
         busy            <= busy_nxt;
         halted          <= halted_nxt;
         err             <= err_nxt;
         retired_cnt     <= retired_nxt;
      end
   end

`ifdef ALU_SEQ_STALL_CNT_EN
   logic stall_c;

   assign stall_c = (((state == S_FETCH_OP) || (state == S_FETCH_ARG)) && !bus.instr_valid)
                    || (state == S_MEM_WAIT);

   // Cycles lost to an empty instruction stream or to memory latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (start && ((state == S_IDLE) || (state == S_HALT))) begin
         stall_cnt <= '0;
      end else if (stall_c && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
